// File: rtl/instr_sequencer.sv
// instr_sequencer: IR/SM/flag registers, HALT/resume handling and one-hot instruction decode.
module instr_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       bus_in,
  input  logic             ir_ld,
  input  logic             sm_en,
  input  logic             cf_en,
  input  logic             zf_en,
  input  logic             alu_cout,
  input  logic             alu_zero,
  input  logic             resume,
  output logic [7:0]       ir,
  output logic             sm,
  output logic             c,
  output logic             z,
  output logic             mova,
  output logic             movb,
  output logic             movc,
  output logic             add,
  output logic             sub,
  output logic             and1,
  output logic             not1,
  output logic             rsr,
  output logic             rsl,
  output logic             jmp,
  output logic             jz,
  output logic             jc,
  output logic             in1,
  output logic             out1,
  output logic             nop,
  output logic             halt,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);
  localparam logic [3:0] MOVA = 4'd0, MOVB = 4'd1, MOVC = 4'd2, ADD = 4'd3;
  localparam logic [3:0] SUB = 4'd4, AND1 = 4'd5, NOT1 = 4'd6, RSR = 4'd7;
  localparam logic [3:0] RSL = 4'd8, JMP = 4'd9, JZ = 4'd10, JC = 4'd11;
  localparam logic [3:0] IN1 = 4'd12, OUT1 = 4'd13, NOP = 4'd14, HALT = 4'd15;
  logic [3:0]  op;
  logic [1:0]  rd;
  logic [1:0]  rs;
  logic [3:0]  idx;
  logic [15:0] lines;
  logic        sm_nxt;
  assign op = ir[7:4];
  assign rd = ir[3:2];
  assign rs = ir[1:0];
  always_comb begin
    idx = op == 4'hF ? (rd == 2'b11 ? MOVB : rs == 2'b11 ? MOVC : MOVA) :
          op == 4'h9 ? ADD :
          op == 4'h6 ? SUB :
          op == 4'hB ? AND1 :
          op == 4'h5 ? NOT1 :
          op == 4'h2 ? IN1 :
          op == 4'h4 ? OUT1 :
          op == 4'hA && rs == 2'b00 ? RSR :
          op == 4'hA && rs == 2'b11 ? RSL :
          ir == 8'h30 ? JMP :
          ir == 8'h31 ? JZ :
          ir == 8'h32 ? JC :
          ir == 8'h80 ? HALT : NOP;
    lines = sm ? 16'(1) << idx : 16'd0;
    sm_nxt = halted && resume ? 1'b0 : sm ^ sm_en;
  end
  assign {halt, nop, out1, in1, jc, jz, jmp, rsl, rsr, not1, and1, sub, add, movc, movb, mova} = lines;
  assign halted = halt;
  always_ff @(posedge clk) begin
    if (rst) begin
      ir        <= 8'h00;
      sm        <= 1'b0;
      c         <= 1'b0;
      z         <= 1'b0;
      instr_cnt <= '0;
    end else begin
      if (ir_ld) ir <= bus_in;
      sm <= sm_nxt;
      if (sm && cf_en) c <= alu_cout;
      if (sm && zf_en) z <= alu_zero;
      if (sm && !sm_nxt) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/execute sequencer and instruction decoder for the model computer: holds the instruction register, the SM fetch/execute state bit and the C/Z flag registers, and decodes IR into the one-hot instruction lines (MOVA…HALT) consumed by the control-signal generator. It is the producer side of the controller interface: it drives the controller's instruction, IR, SM, Z and C inputs and takes IR_LD, SM_EN, CF_EN and ZF_EN back from it.

## Interface
- `CNT_W`, 16, width of the retired-instruction counter.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bus_in`  in  8  data bus value (RAM output during fetch).
- `ir_ld`  in  1  IR load enable from controller (IR_LD).
- `sm_en`  in  1  SM toggle enable from controller (SM_EN).
- `cf_en`  in  1  carry-flag update enable (CF_EN).
- `zf_en`  in  1  zero-flag update enable (ZF_EN).
- `alu_cout`  in  1  ALU/shifter carry out.
- `alu_zero`  in  1  ALU result is zero.
- `resume`  in  1  leave halted state (level, sampled each cycle).
- `ir`  out  8  instruction register.
- `sm`  out  1  0 = fetch cycle, 1 = execute cycle.
- `c`, `z`  out  1 each  carry and zero flags.
- `mova, movb, movc, add, sub, and1, not1, rsr, rsl, jmp, jz, jc, in1, out1, nop, halt`  out  1 each  one-hot instruction lines.
- `halted`  out  1  processor stopped on HALT.
- `instr_cnt`  out  CNT_W  retired-instruction count.

## Operation
- Decode fields: opcode = ir[7:4], Rd = ir[3:2], Rs = ir[1:0].
- Opcode map (first match wins):
  - 1111, Rd=11 → MOVB; 1111, Rs=11 → MOVC; 1111 otherwise → MOVA.
  - 1001 ADD; 0110 SUB; 1011 AND1; 0101 NOT1; 0010 IN1; 0100 OUT1.
  - 1010 with Rs=00 → RSR; 1010 with Rs=11 → RSL.
  - 0011 0000 JMP; 0011 0001 JZ; 0011 0010 JC.
  - 1000 0000 HALT; 0111 0000 NOP.
  - Every other encoding (incl. 0x00, 1010 with Rs=01/10) → NOP.
- Instruction lines = sm & decode(ir): exactly one line high when sm=1, all low when sm=0.
- IR: loads bus_in on edge where ir_ld=1; otherwise holds.
- SM: toggles on edge where sm_en=1; holds when sm_en=0.
- Flags update only when sm=1: c ← alu_cout if cf_en; z ← alu_zero if zf_en; independent of each other.
- HALT: controller drops sm_en, so sm stays 1 and halt stays high; halted = halt line.
- Resume: edge with halted=1 and resume=1 forces sm←0 (next fetch; PC was already advanced during HALT fetch). resume ignored when not halted.
- instr_cnt increments (mod 2^CNT_W) on every edge where sm goes 1→0, including resume exit from HALT.

## Timing
- Reset values: ir=0x00, sm=0, c=0, z=0, instr_cnt=0; hence all instruction lines, halted = 0. First post-reset cycle is a fetch.
- Normal instruction: 2 cycles, fetch (sm=0, IR captured) then execute (sm=1, lines valid whole cycle).
- Decode latency: lines valid combinationally from registered ir/sm, 0 cycles after sm rises.
- Flag results visible in cycle after execute (i.e. next fetch); a JZ/JC sees flags from any earlier instruction.
- rst dominates ir_ld, sm_en, resume and flag enables in the same cycle; reset mid-execute or while halted returns to fetch with cleared flags and counter.
- ir_ld=1 while sm=1 (controller fault) still loads IR; no protection required.
- cf_en/zf_en while sm=0 ignored.

## Test plan
- Reset then bus_in=0x94 (ADD R1,R0) with ir_ld=1, sm_en=1 → after edge ir=0x94, sm=1, add=1 only; next edge sm=0, instr_cnt=1.
- Execute ADD with cf_en=zf_en=1, alu_cout=1, alu_zero=1 → c=1, z=1 next cycle; SUB with alu_zero=0, cf_en=1, alu_cout=0 → c=0, z=0.
- Decode sweep: 0xFD→MOVB, 0xF7→MOVC, 0xF4→MOVA, 0xA4→RSR, 0xA7→RSL, 0x30/0x31/0x32→JMP/JZ/JC, 0xA5 and 0x00→NOP; all lines 0 while sm=0.
- Load 0x80 with sm_en=0 in execute → halt=halted=1 held 10 cycles, instr_cnt unchanged; resume=1 → sm=0, halted=0, instr_cnt+1.
- Assert rst during execute of 0x60 with c=z=1 → next cycle sm=0, ir=0x00, c=z=0, instr_cnt=0.
- Run 2^CNT_W instructions → instr_cnt wraps to 0.
